vga_pixel_fetch: RTL and testbench

Pixel pipeline stage directly downstream of the VGA timing generator. Consumes the generator's pixel coordinates, blanking and sync, fetches the matching framebuffer byte from a fixed-latency synchronous memory, expands RGB332 to 24-bit colour, and delays sync and blank so they stay aligned with the colour it drives to the DAC. The source image is 320x240 and is scaled 2x to fill the 640x480 visible area.

---
 rtl/vga_pixel_fetch_if.sv | 16 +
 rtl/vga_pixel_fetch.sv | 142 ++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pixel_fetch_if : framebuffer read bus (address/read out, byte back)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 17
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;

    modport master (output mem_addr, output mem_rd, input  mem_data);
    modport slave  (input  mem_addr, input  mem_rd, output mem_data);
endinterface
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pixel_fetch : 2x-scaled RGB332 framebuffer fetch with aligned syncs   |
// | Optional colour-bar source via `VGA_TEST_PATTERN_EN (adds test_en).       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_pixel_fetch #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int ADDR_W  = 17,
    parameter int MEM_LAT = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  wire logic       test_en,
`endif
    input  wire logic [9:0] posx,
    input  wire logic [9:0] posy,
    input  wire logic       blank_n_in,
    input  wire logic       h_sync_in,
    input  wire logic       v_sync_in,
    vga_pixel_fetch_if.master mem,
    output logic [7:0]      r,
    output logic [7:0]      g,
    output logic [7:0]      b,
    output logic            h_sync_out,
    output logic            v_sync_out,
    output logic            blank_n_out,
    output logic            frame_start
);

    typedef struct packed {
        logic       valid;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       first;
        logic       tp;
        logic [2:0] bar;
    } side_t;

    logic [8:0]        w_sx;
    logic [8:0]        w_sy;
    logic              w_in_range;
    logic              w_test;
    logic [9:0]        w_bar_q;
    logic [2:0]        w_bar;
    logic [ADDR_W-1:0] w_addr;
    side_t             w_stage_a;
    side_t             w_last;
    logic [7:0]        w_r;
    logic [7:0]        w_g;
    logic [7:0]        w_b;

    // Index 0 is stage A; index MEM_LAT lines up with mem_data.
    side_t             r_pipe [0:MEM_LAT];
    logic [ADDR_W-1:0] r_addr;

`ifdef VGA_TEST_PATTERN_EN
    assign w_test = test_en;
`else
    assign w_test = 1'b0;
`endif

    assign w_sx       = posx[9:1];
    assign w_sy       = posy[9:1];
    assign w_in_range = (32'(w_sx) < IMG_W) && (32'(w_sy) < IMG_H);
    assign w_addr     = ADDR_W'(32'(w_sy) * 32'(IMG_W) + 32'(w_sx));
    assign w_bar_q    = posx / 10'd80;
    assign w_bar      = (w_bar_q > 10'd7) ? 3'd7 : w_bar_q[2:0];

    always_comb begin
        w_stage_a       = '0;
        w_stage_a.valid = blank_n_in & w_in_range & ~w_test;
        w_stage_a.hs    = h_sync_in;
        w_stage_a.vs    = v_sync_in;
        w_stage_a.bn    = blank_n_in;
        w_stage_a.first = blank_n_in & (posx == 10'd0) & (posy == 10'd0);
        w_stage_a.tp    = w_test;
        w_stage_a.bar   = w_bar;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_addr    <= w_addr;
            r_pipe[0] <= w_stage_a;
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign mem.mem_addr = r_addr;
    assign mem.mem_rd   = r_pipe[0].valid;
    assign w_last       = r_pipe[MEM_LAT];

    // Memory data is only trusted when the matching read was issued.
    always_comb begin
        w_r = 8'h00;
        w_g = 8'h00;
        w_b = 8'h00;
        if (w_last.tp) begin
            if (w_last.bn) begin
                w_r = {8{w_last.bar[2]}};
                w_g = {8{w_last.bar[1]}};
                w_b = {8{w_last.bar[0]}};
            end
        end else if (w_last.valid) begin
            w_r = {mem.mem_data[7:5], mem.mem_data[7:5], mem.mem_data[7:6]};
            w_g = {mem.mem_data[4:2], mem.mem_data[4:2], mem.mem_data[4:3]};
            w_b = {4{mem.mem_data[1:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r           <= 8'h00;
            g           <= 8'h00;
            b           <= 8'h00;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            blank_n_out <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r           <= w_r;
            g           <= w_g;
            b           <= w_b;
            h_sync_out  <= w_last.hs;
            v_sync_out  <= w_last.vs;
            blank_n_out <= w_last.bn;
            frame_start <= w_last.first;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_pixel_fetch : randomized + directed bench with a pixel-level model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vga_pixel_fetch;

    localparam int IMG_W   = 320;
    localparam int IMG_H   = 240;
    localparam int ADDR_W  = 17;
    localparam int MEM_LAT = 2;
    localparam int LAT     = MEM_LAT + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       blank_n_in;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       h_sync_out;
    logic       v_sync_out;
    logic       blank_n_out;
    logic       frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_en;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int fs_seen = 0;

    vga_pixel_fetch_if #(.ADDR_W(ADDR_W)) mem_if ();

    vga_pixel_fetch #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_en     (test_en),
`endif
        .posx        (posx),
        .posy        (posy),
        .blank_n_in  (blank_n_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .mem         (mem_if),
        .r           (r),
        .g           (g),
        .b           (b),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .blank_n_out (blank_n_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer with a fixed MEM_LAT-cycle read pipeline.
    logic [7:0] fb [0:(1<<ADDR_W)-1];
    logic [7:0] mem_pipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        mem_pipe[0] <= fb[mem_if.mem_addr];
        for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_if.mem_data = mem_pipe[MEM_LAT-1];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic [23:0]       rgb;
        logic [3:0]        side;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Colour as scaled intensity: a 3-bit level maps to round(v*255/7), 2-bit to v*85.
    function automatic exp_t model(int x, int y, bit bn, bit hs, bit vs, bit te);
        exp_t e;
        int sx = x / 2;
        int sy = y / 2;
        int k;
        int rv, gv, bv;
        logic [7:0] d;
        e.addr = ADDR_W'(sy * IMG_W + sx);
        e.rd   = bn && (sx < IMG_W) && (sy < IMG_H) && !te;
        e.rgb  = 24'h0;
        if (te) begin
            k = x / 80;
            if (k > 7) k = 7;
            if (bn) e.rgb = {(k >= 4) ? 8'hFF : 8'h00,
                             ((k / 2) % 2 == 1) ? 8'hFF : 8'h00,
                             (k % 2 == 1) ? 8'hFF : 8'h00};
        end else if (e.rd) begin
            d  = fb[e.addr];
            rv = (int'(d[7:5]) * 510 + 7) / 14;
            gv = (int'(d[4:2]) * 510 + 7) / 14;
            bv = int'(d[1:0]) * 85;
            e.rgb = {8'(rv), 8'(gv), 8'(bv)};
        end
        e.side = {hs, vs, bn, bn && (x == 0) && (y == 0)};
        return e;
    endfunction

    task automatic prefill();
        exp_t z;
        z.addr = '0; z.rd = 1'b0; z.rgb = 24'h0; z.side = 4'h0;
        q.delete();
        repeat (LAT-1) q.push_back(z);
    endtask

    task automatic step(input int x, input int y, input bit bn, input bit hs,
                        input bit vs, input bit te);
        exp_t e, o;
        @(negedge clk);
        posx = 10'(x); posy = 10'(y);
        blank_n_in = bn; h_sync_in = hs; v_sync_in = vs;
`ifdef VGA_TEST_PATTERN_EN
        test_en = te;
`endif
        e = model(x, y, bn, hs, vs, te);
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("mem_rd", 32'(mem_if.mem_rd), 32'(e.rd));
        chk("mem_addr", 32'(mem_if.mem_addr), 32'(e.addr));
        o = q.pop_front();
        chk("rgb", {8'h0, r, g, b}, {8'h0, o.rgb});
        chk("sync_blank_fs", 32'({h_sync_out, v_sync_out, blank_n_out, frame_start}), 32'(o.side));
        if (frame_start) fs_seen++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_if.mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_if.mem_addr), 32'd0);
        chk({tag, "_rgb"}, {8'h0, r, g, b}, 32'd0);
        chk({tag, "_side"}, 32'({h_sync_out, v_sync_out, blank_n_out, frame_start}), 32'd0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        prefill();
    endtask

    initial begin
        rst = 1'b1;
        posx = '0; posy = '0; blank_n_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        test_en = 1'b0;
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) fb[i] = 8'($urandom);
        fb[321] = 8'hE0; fb[322] = 8'h1C; fb[323] = 8'h03; fb[324] = 8'h92; fb[325] = 8'hFF;

        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        #1 rst = 1'b1;
        prefill();

        // Directed pixels and blanking/sync behaviour
        step(2, 2, 1, 0, 0, 0);
        step(4, 2, 1, 0, 0, 0);
        step(6, 2, 1, 0, 0, 0);
        step(8, 2, 1, 0, 0, 0);
        step(10, 2, 0, 1, 0, 0);
        step(10, 2, 0, 0, 1, 0);
        step(10, 2, 0, 1, 1, 0);
        step(10, 2, 0, 0, 0, 0);

        // Raster across the frame wrap with blanking intervals
        fs_seen = 0;
        for (int li = 0; li < 6; li++) begin
            int y;
            y = (476 + li) % 480;
            for (int x = 0; x < 640; x++) begin
                step(x, y, 1, 0, (y < 2) ? 1'b1 : 1'b0, 0);
                if (x == 639 && y == 479) chk("last_addr", 32'(mem_if.mem_addr), 32'd76799);
            end
            for (int hb = 0; hb < 20; hb++)
                step($urandom_range(0, 639), y, 0, (hb >= 4 && hb < 12) ? 1'b1 : 1'b0, 0, 0);
        end
        repeat (LAT) step(0, 0, 0, 0, 0, 0);
        chk("frame_start_count", 32'(fs_seen), 32'd1);

        // Async reset mid-line, then resume
        for (int x = 0; x <= 300; x++) step(x, 100, 1, 0, 0, 0);
        reset_mid();
        for (int x = 301; x < 640; x++) step(x, 100, 1, 0, 0, 0);

        // Random coordinates including out-of-range positions
        for (int n = 0; n < 2000; n++)
            step($urandom_range(0, 1023), $urandom_range(0, 1023),
                 1'($urandom), 1'($urandom), 1'($urandom), 0);

`ifdef VGA_TEST_PATTERN_EN
        step(0, 10, 1, 0, 0, 1);
        step(80, 10, 1, 0, 0, 1);
        step(560, 10, 1, 0, 0, 1);
        step(560, 10, 0, 0, 0, 1);
        for (int n = 0; n < 1000; n++)
            step($urandom_range(0, 1023), $urandom_range(0, 1023),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`endif
        repeat (LAT) step(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
